// File: rtl/framebuffer_filler_pkg.sv
// Shared definitions for the framebuffer rectangle filler: controller states,
// default framebuffer geometry and the row-offset helper used at command latch.
package IllusionPkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2
   } fill_state_e;

   localparam int unsigned FB_WIDTH  = 320;
   localparam int unsigned FB_HEIGHT = 240;

   // y*w as a shift-and-add over the 8 row bits; w is a constant, so this
   // reduces to a fixed adder tree rather than a general multiplier.
   function automatic logic [31:0] row_offset(input logic [7:0] y, input int unsigned w);
      logic [31:0] acc;
      acc = '0;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) acc = acc + (32'(w) << i);
      end
      return acc;
   endfunction

endpackage

// File: rtl/framebuffer_filler.sv
// Rectangle filler for the back buffer: latches a command, streams one pixel
// write per cycle in raster order, and handshakes end-of-frame with the display.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready for a command; aEndFrame alone moves to ST_DONE
// ST_FILL | one pixel write per cycle, x fastest then y
// ST_DONE | back buffer complete, waiting for aFrameFlipped
module framebuffer_filler
   import IllusionPkg::*;
#(
   parameter int unsigned WIDTH  = FB_WIDTH,
   parameter int unsigned HEIGHT = FB_HEIGHT
) (
   input  logic        aClock,
   input  logic        aReset,
   input  logic        aStart,
   input  logic [8:0]  aX0,
   input  logic [8:0]  aX1,
   input  logic [7:0]  aY0,
   input  logic [7:0]  aY1,
   input  logic [2:0]  aColor,
   input  logic        aEndFrame,
   input  logic        aFrameFlipped,
   output logic        anOutReady,
   output logic [31:0] anOutPixelAddr,
   output logic [2:0]  anOutPixelData,
   output logic        anOutPixelWrite,
   output logic        anOutFrameDone
);

   localparam logic [8:0] X_LIM = 9'(WIDTH - 1);
   localparam logic [7:0] Y_LIM = 8'(HEIGHT - 1);

   fill_state_e state_q, state_d;
   logic [8:0]  x_q, x_d;
   logic [7:0]  y_q, y_d;
   logic [8:0]  min_x_q, min_x_d;
   logic [8:0]  max_x_q, max_x_d;
   logic [7:0]  max_y_q, max_y_d;
   logic [31:0] row_base_q, row_base_d;
   logic [2:0]  color_q, color_d;
   logic        end_pend_q, end_pend_d;

   logic [8:0]  lo_x, hi_x, cl_lo_x, cl_hi_x;
   logic [7:0]  lo_y, hi_y, cl_lo_y, cl_hi_y;

   // Order first, then clamp, so an out-of-range bound collapses onto the edge.
   always_comb begin
      lo_x    = (aX0 > aX1) ? aX1 : aX0;
      hi_x    = (aX0 > aX1) ? aX0 : aX1;
      lo_y    = (aY0 > aY1) ? aY1 : aY0;
      hi_y    = (aY0 > aY1) ? aY0 : aY1;
      cl_lo_x = (lo_x > X_LIM) ? X_LIM : lo_x;
      cl_hi_x = (hi_x > X_LIM) ? X_LIM : hi_x;
      cl_lo_y = (lo_y > Y_LIM) ? Y_LIM : lo_y;
      cl_hi_y = (hi_y > Y_LIM) ? Y_LIM : hi_y;
   end

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      min_x_d    = min_x_q;
      max_x_d    = max_x_q;
      max_y_d    = max_y_q;
      row_base_d = row_base_q;
      color_d    = color_q;
      end_pend_d = end_pend_q;

      case (state_q)
         ST_IDLE: begin
            if (aStart) begin
               state_d    = ST_FILL;
               min_x_d    = cl_lo_x;
               max_x_d    = cl_hi_x;
               max_y_d    = cl_hi_y;
               x_d        = cl_lo_x;
               y_d        = cl_lo_y;
               row_base_d = row_offset(cl_lo_y, WIDTH);
               color_d    = aColor;
               end_pend_d = aEndFrame;
            end else if (aEndFrame) begin
               state_d = ST_DONE;
            end
         end
         ST_FILL: begin
            if (aEndFrame) end_pend_d = 1'b1;
            if (x_q == max_x_q) begin
               if (y_q == max_y_q) begin
                  state_d    = (end_pend_q || aEndFrame) ? ST_DONE : ST_IDLE;
                  end_pend_d = 1'b0;
               end else begin
                  x_d        = min_x_q;
                  y_d        = y_q + 8'd1;
                  row_base_d = row_base_q + 32'(WIDTH);
               end
            end else begin
               x_d = x_q + 9'd1;
            end
         end
         ST_DONE: begin
            if (aFrameFlipped) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge aClock or negedge aReset) begin
      if (!aReset) begin
         state_q    <= ST_IDLE;
         x_q        <= '0;
         y_q        <= '0;
         min_x_q    <= '0;
         max_x_q    <= '0;
         max_y_q    <= '0;
         row_base_q <= '0;
         color_q    <= '0;
         end_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         min_x_q    <= min_x_d;
         max_x_q    <= max_x_d;
         max_y_q    <= max_y_d;
         row_base_q <= row_base_d;
         color_q    <= color_d;
         end_pend_q <= end_pend_d;
      end
   end

   assign anOutReady      = (state_q == ST_IDLE);
   assign anOutPixelWrite = (state_q == ST_FILL);
   assign anOutFrameDone  = (state_q == ST_DONE);
   assign anOutPixelAddr  = row_base_q + 32'(x_q);
   assign anOutPixelData  = color_q;

endmodule

// File: tb/tb_framebuffer_filler.sv
// Directed bench for framebuffer_filler: hand-computed write sequences,
// bound ordering/clamping, end-of-frame handshake and mid-fill reset.
module tb_framebuffer_filler;

   logic        aClock = 1'b0;
   logic        aReset;
   logic        aStart;
   logic [8:0]  aX0, aX1;
   logic [7:0]  aY0, aY1;
   logic [2:0]  aColor;
   logic        aEndFrame;
   logic        aFrameFlipped;
   logic        anOutReady;
   logic [31:0] anOutPixelAddr;
   logic [2:0]  anOutPixelData;
   logic        anOutPixelWrite;
   logic        anOutFrameDone;

   int tests_run = 0;
   int tests_failed = 0;

   framebuffer_filler #(.WIDTH(320), .HEIGHT(240)) dut (
      .aClock         (aClock),
      .aReset         (aReset),
      .aStart         (aStart),
      .aX0            (aX0),
      .aX1            (aX1),
      .aY0            (aY0),
      .aY1            (aY1),
      .aColor         (aColor),
      .aEndFrame      (aEndFrame),
      .aFrameFlipped  (aFrameFlipped),
      .anOutReady     (anOutReady),
      .anOutPixelAddr (anOutPixelAddr),
      .anOutPixelData (anOutPixelData),
      .anOutPixelWrite(anOutPixelWrite),
      .anOutFrameDone (anOutFrameDone)
   );

   always #5 aClock = ~aClock;

   task automatic tick();
      @(posedge aClock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic idle_outputs(input string tag);
      chk({tag, "_ready"}, 32'(anOutReady), 32'd1);
      chk({tag, "_write"}, 32'(anOutPixelWrite), 32'd0);
      chk({tag, "_done"}, 32'(anOutFrameDone), 32'd0);
   endtask

   task automatic cmd(input logic [8:0] x0, input logic [8:0] x1,
                      input logic [7:0] y0, input logic [7:0] y1,
                      input logic [2:0] col, input logic endf);
      aX0 = x0; aX1 = x1; aY0 = y0; aY1 = y1; aColor = col;
      aStart = 1'b1; aEndFrame = endf;
      tick();
      aStart = 1'b0; aEndFrame = 1'b0;
   endtask

   logic [31:0] exp_rect [6];

   initial begin
      exp_rect[0] = 32'd962;  exp_rect[1] = 32'd963;  exp_rect[2] = 32'd964;
      exp_rect[3] = 32'd1282; exp_rect[4] = 32'd1283; exp_rect[5] = 32'd1284;

      aReset = 1'b0; aStart = 1'b0; aEndFrame = 1'b0; aFrameFlipped = 1'b0;
      aX0 = '0; aX1 = '0; aY0 = '0; aY1 = '0; aColor = '0;
      #12;
      idle_outputs("rst");
      chk("rst_addr", anOutPixelAddr, 32'd0);
      chk("rst_data", 32'(anOutPixelData), 32'd0);
      tick();
      aReset = 1'b1;
      tick();
      idle_outputs("post_rst");

      // Ordered rectangle (2,3)-(4,4), colour 5
      cmd(9'd2, 9'd4, 8'd3, 8'd4, 3'd5, 1'b0);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("fwd_wr%0d", i), 32'(anOutPixelWrite), 32'd1);
         chk($sformatf("fwd_addr%0d", i), anOutPixelAddr, exp_rect[i]);
         chk($sformatf("fwd_data%0d", i), 32'(anOutPixelData), 32'd5);
         chk($sformatf("fwd_rdy%0d", i), 32'(anOutReady), 32'd0);
         tick();
      end
      idle_outputs("fwd_end");

      // Reversed bounds give the same sequence; a start mid-fill is ignored
      cmd(9'd4, 9'd2, 8'd4, 8'd3, 3'd5, 1'b0);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("rev_wr%0d", i), 32'(anOutPixelWrite), 32'd1);
         chk($sformatf("rev_addr%0d", i), anOutPixelAddr, exp_rect[i]);
         chk($sformatf("rev_data%0d", i), 32'(anOutPixelData), 32'd5);
         if (i == 2) begin
            aX0 = 9'd100; aX1 = 9'd110; aY0 = 8'd50; aY1 = 8'd60; aColor = 3'd7;
            aStart = 1'b1;
         end
         tick();
         aStart = 1'b0;
      end
      idle_outputs("rev_end");

      // Clamping: single pixel at (319,239)
      cmd(9'd319, 9'd400, 8'd239, 8'd250, 3'd3, 1'b0);
      chk("clamp_wr", 32'(anOutPixelWrite), 32'd1);
      chk("clamp_addr", anOutPixelAddr, 32'd76799);
      chk("clamp_data", 32'(anOutPixelData), 32'd3);
      tick();
      idle_outputs("clamp_end");

      // Flip outside DONE is ignored
      aFrameFlipped = 1'b1;
      tick();
      aFrameFlipped = 1'b0;
      idle_outputs("flip_idle");

      // End-of-frame requested during a 2-pixel fill
      cmd(9'd0, 9'd1, 8'd0, 8'd0, 3'd6, 1'b0);
      chk("ef_wr0", 32'(anOutPixelWrite), 32'd1);
      chk("ef_addr0", anOutPixelAddr, 32'd0);
      chk("ef_done0", 32'(anOutFrameDone), 32'd0);
      aEndFrame = 1'b1;
      tick();
      aEndFrame = 1'b0;
      chk("ef_wr1", 32'(anOutPixelWrite), 32'd1);
      chk("ef_addr1", anOutPixelAddr, 32'd1);
      chk("ef_done1", 32'(anOutFrameDone), 32'd0);
      tick();
      chk("ef_done_rise", 32'(anOutFrameDone), 32'd1);
      chk("ef_wr_off", 32'(anOutPixelWrite), 32'd0);
      chk("ef_rdy_off", 32'(anOutReady), 32'd0);
      cmd(9'd5, 9'd6, 8'd5, 8'd6, 3'd1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("ef_hold_done%0d", i), 32'(anOutFrameDone), 32'd1);
         chk($sformatf("ef_hold_wr%0d", i), 32'(anOutPixelWrite), 32'd0);
         tick();
      end
      aFrameFlipped = 1'b1;
      tick();
      aFrameFlipped = 1'b0;
      idle_outputs("ef_flipped");
      tick();
      idle_outputs("ef_stay_idle");

      // Reset asserted during the third write of (0,0)-(9,0)
      cmd(9'd0, 9'd9, 8'd0, 8'd0, 3'd2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_fill_wr%0d", i), 32'(anOutPixelWrite), 32'd1);
         chk($sformatf("rst_fill_addr%0d", i), anOutPixelAddr, 32'(i));
         if (i < 2) tick();
      end
      aReset = 1'b0;
      #1;
      idle_outputs("rst_mid");
      chk("rst_mid_addr", anOutPixelAddr, 32'd0);
      tick();
      aReset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         idle_outputs($sformatf("rst_after%0d", i));
      end

      // Start and end-of-frame together: start wins, end stays pending
      cmd(9'd0, 9'd0, 8'd0, 8'd0, 3'd4, 1'b1);
      chk("se_wr", 32'(anOutPixelWrite), 32'd1);
      chk("se_addr", anOutPixelAddr, 32'd0);
      chk("se_data", 32'(anOutPixelData), 32'd4);
      chk("se_done0", 32'(anOutFrameDone), 32'd0);
      tick();
      chk("se_wr_off", 32'(anOutPixelWrite), 32'd0);
      chk("se_done1", 32'(anOutFrameDone), 32'd1);
      aFrameFlipped = 1'b1;
      tick();
      aFrameFlipped = 1'b0;
      idle_outputs("se_flipped");

      // End-of-frame alone from IDLE
      aEndFrame = 1'b1;
      tick();
      aEndFrame = 1'b0;
      chk("idle_ef_done", 32'(anOutFrameDone), 32'd1);
      chk("idle_ef_rdy", 32'(anOutReady), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #50000;
      tests_failed++;
      $display("FAIL timeout: observed no completion, expected completion before 50000");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $fatal(1, "timeout");
   end

endmodule
